// File: rtl/denise_sprite_serializer_pkg.sv
// denise_sprite_serializer_pkg: shared sprite register map, FSM encoding and pixel constants
package denise_sprite_serializer_pkg;
  localparam int SPR0POS = 'h140;
  localparam int SPR_STRIDE = 8;
  localparam logic [1:0] NSPR_TRANSPARENT = 2'b00;
  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} spr_state_t;
  // Byte address of a sprite register, reduced to the word address seen on reg_address_in[8:1]
  function automatic logic [7:0] spr_word_addr(input int sprnum, input int offs);
    return 8'((SPR0POS + SPR_STRIDE * sprnum + offs) >> 1);
  endfunction
endpackage

// File: rtl/denise_sprite_shifter.sv
// denise_sprite_shifter: 16-bit dual pixel shifter with load and pixel counter
//   clk, reset_n : clock, async active-low reset
//   en           : pixel enable; load : copy data_in/datb_in and restart count at 15
//   msb          : {datb[15], data[15]} current pixel; cnt : pixels remaining after this one
module denise_sprite_shifter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [15:0] datb_in,
  output logic [1:0]  msb,
  output logic [3:0]  cnt
);
  logic [15:0] data_q, data_d, datb_q, datb_d;
  logic [3:0] cnt_q, cnt_d;
  always_comb begin
    data_d = !en ? data_q : load ? data_in : {data_q[14:0], 1'b0};
    datb_d = !en ? datb_q : load ? datb_in : {datb_q[14:0], 1'b0};
    cnt_d = !en ? cnt_q : load ? 4'd15 : (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      datb_q <= '0;
      cnt_q <= '0;
    end else begin
      data_q <= data_d;
      datb_q <= datb_d;
      cnt_q <= cnt_d;
    end
  end
  assign msb = {datb_q[15], data_q[15]};
  assign cnt = cnt_q;
endmodule

// File: rtl/denise_sprite_serializer.sv
// denise_sprite_serializer: one Denise sprite channel - register latches, hstart comparator, pixel serializer
//   clk, reset_n   : clock, async active-low reset; clk7_en : pixel/register enable
//   reg_address_in : register word address [8:1]; data_in : register write data
//   hpos           : beam lores pixel position
//   nsprite        : {DATB, DATA} pixel, 00 transparent; attach : CTL[7]; armed : comparator enabled
module denise_sprite_serializer
  import denise_sprite_serializer_pkg::*;
#(
  parameter int SPRNUM = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk7_en,
  input  logic [7:0]  reg_address_in,
  input  logic [15:0] data_in,
  input  logic [8:0]  hpos,
  output logic [1:0]  nsprite,
  output logic        attach,
  output logic        armed
);
  localparam logic [7:0] A_POS = spr_word_addr(SPRNUM, 0);
  localparam logic [7:0] A_CTL = spr_word_addr(SPRNUM, 2);
  localparam logic [7:0] A_DATA = spr_word_addr(SPRNUM, 4);
  localparam logic [7:0] A_DATB = spr_word_addr(SPRNUM, 6);
  spr_state_t state_q, state_d;
  logic [8:0] hstart_q, hstart_d;
  logic [15:0] data_latch_q, data_latch_d, datb_latch_q, datb_latch_d;
  logic attach_q, attach_d, armed_q, armed_d;
  logic [1:0] nsprite_q, nsprite_d, shift_msb;
  logic [3:0] cnt;
  logic wr_pos, wr_ctl, wr_data, wr_datb, match;
  assign wr_pos = clk7_en && reg_address_in == A_POS;
  assign wr_ctl = clk7_en && reg_address_in == A_CTL;
  assign wr_data = clk7_en && reg_address_in == A_DATA;
  assign wr_datb = clk7_en && reg_address_in == A_DATB;
  // Compare with the pre-write hstart/armed so a same-enable write never affects this pixel
  assign match = armed_q && hpos == hstart_q;
  always_comb begin
    hstart_d = wr_pos ? {data_in[7:0], hstart_q[0]} : wr_ctl ? {hstart_q[8:1], data_in[0]} : hstart_q;
    attach_d = wr_ctl ? data_in[7] : attach_q;
    armed_d = wr_ctl ? 1'b0 : wr_data ? 1'b1 : armed_q;
    data_latch_d = wr_data ? data_in : data_latch_q;
    datb_latch_d = wr_datb ? data_in : datb_latch_q;
    // A burst runs until its last pixel, then the FSM settles according to the new armed value
    state_d = !clk7_en ? state_q : match ? SHIFT : (state_q == SHIFT && cnt != 4'd0) ? SHIFT : armed_d ? ARMED : IDLE;
    nsprite_d = !clk7_en ? nsprite_q : (state_q == SHIFT) ? shift_msb : NSPR_TRANSPARENT;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hstart_q <= '0;
      attach_q <= 1'b0;
      armed_q <= 1'b0;
      data_latch_q <= '0;
      datb_latch_q <= '0;
      nsprite_q <= NSPR_TRANSPARENT;
    end else begin
      state_q <= state_d;
      hstart_q <= hstart_d;
      attach_q <= attach_d;
      armed_q <= armed_d;
      data_latch_q <= data_latch_d;
      datb_latch_q <= datb_latch_d;
      nsprite_q <= nsprite_d;
    end
  end
  denise_sprite_shifter u_shifter (
    .clk(clk),
    .reset_n(reset_n),
    .en(clk7_en),
    .load(clk7_en && match),
    .data_in(data_latch_q),
    .datb_in(datb_latch_q),
    .msb(shift_msb),
    .cnt(cnt)
  );
  assign nsprite = nsprite_q;
  assign attach = attach_q;
  assign armed = armed_q;
endmodule

// File: tb/tb_denise_sprite_serializer.sv
// tb_denise_sprite_serializer: scoreboarded random/directed bench for one sprite channel
module tb_denise_sprite_serializer;
  localparam logic [7:0] A_POS = 8'hA0, A_CTL = 8'hA1, A_DATA = 8'hA2, A_DATB = 8'hA3;
  logic clk = 1'b0, reset_n = 1'b0, clk7_en = 1'b0;
  logic [7:0] reg_address_in = 8'h00;
  logic [15:0] data_in = '0;
  logic [8:0] hpos = '0;
  logic [1:0] nsprite;
  logic attach, armed;
  int checks = 0, errors = 0;
  logic [8:0] hp = '0, hp_mask = 9'h1FF;
  logic [3:0] exp_q[$];
  // model state: register contents plus the enable index of the most recent burst start
  logic [15:0] m_data = '0, m_datb = '0, m_a = '0, m_b = '0;
  logic [8:0] m_hs = '0;
  logic m_att = 1'b0, m_arm = 1'b0;
  logic [1:0] m_ns = 2'b00;
  int en_cnt = 0, last_load = -100;
  always #5 clk = ~clk;
  denise_sprite_serializer #(.SPRNUM(0)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clk7_en(clk7_en),
    .reg_address_in(reg_address_in),
    .data_in(data_in),
    .hpos(hpos),
    .nsprite(nsprite),
    .attach(attach),
    .armed(armed)
  );
  // Reference model: pixel d (1..16) enables after a burst start shows bit 16-d of the loaded words
  always @(posedge clk) begin
    if (!reset_n) begin
      m_data = '0; m_datb = '0; m_a = '0; m_b = '0; m_hs = '0;
      m_att = 1'b0; m_arm = 1'b0; m_ns = 2'b00; last_load = -100;
    end else if (clk7_en) begin
      int d;
      d = en_cnt - last_load;
      m_ns = (d >= 1 && d <= 16) ? {m_b[16-d], m_a[16-d]} : 2'b00;
      if (m_arm && hpos == m_hs) begin
        m_a = m_data; m_b = m_datb; last_load = en_cnt;
      end
      if (reg_address_in == A_POS) m_hs[8:1] = data_in[7:0];
      if (reg_address_in == A_CTL) begin m_hs[0] = data_in[0]; m_att = data_in[7]; m_arm = 1'b0; end
      if (reg_address_in == A_DATA) begin m_data = data_in; m_arm = 1'b1; end
      if (reg_address_in == A_DATB) m_datb = data_in;
      en_cnt++;
    end
    exp_q.push_back({m_ns, m_att, m_arm});
  end
  always @(posedge clk) begin
    logic [3:0] e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (nsprite !== e[3:2]) begin
        errors++;
        $display("FAIL nsprite t=%0t got=%b exp=%b", $time, nsprite, e[3:2]);
      end
      checks++;
      if ({attach, armed} !== e[1:0]) begin
        errors++;
        $display("FAIL attach_armed t=%0t got=%b exp=%b", $time, {attach, armed}, e[1:0]);
      end
    end
  end
  task automatic step(input logic en, input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    clk7_en = en; reg_address_in = a; data_in = d; hpos = hp;
    if (en) hp = (hp + 9'd1) & hp_mask;
  endtask
  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    step(1'b1, a, d);
  endtask
  task automatic pix(input int n);
    repeat (n) step(1'b1, 8'h00, 16'($urandom));
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    hp = 9'd0;
    pix(512);
    hp = 9'h070;
    wr(A_POS, 16'h0040); wr(A_CTL, 16'h0000); wr(A_DATB, 16'h0000); wr(A_DATA, 16'h8001);
    pix(48);
    hp = 9'h070;
    wr(A_POS, 16'h0040); wr(A_CTL, 16'h0001); wr(A_DATB, 16'hAAAA); wr(A_DATA, 16'hFFFF);
    pix(48);
    hp = 9'h070;
    pix(22);
    wr(A_CTL, 16'h0001);
    pix(560);
    hp = 9'h070;
    wr(A_POS, 16'h0040); wr(A_CTL, 16'h0000); wr(A_DATB, 16'hFFFF); wr(A_DATA, 16'hFFFF);
    pix(15);
    wr(A_DATA, 16'h0000); wr(A_DATB, 16'h0000);
    pix(3);
    hp = 9'h080;
    pix(30);
    hp = 9'h070;
    wr(A_POS, 16'h0040); wr(A_CTL, 16'h0081); wr(A_DATB, 16'h1234); wr(A_DATA, 16'hFFFF);
    pix(20);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (nsprite !== 2'b00) begin
      errors++;
      $display("FAIL async_reset_nsprite got=%b exp=00", nsprite);
    end
    checks++;
    if ({attach, armed} !== 2'b00) begin
      errors++;
      $display("FAIL async_reset_attach_armed got=%b exp=00", {attach, armed});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pix(40);
    hp_mask = 9'h03F;
    hp = 9'h000;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom % 16);
      if (r == 0) wr(A_POS, {8'($urandom), 3'b000, 5'($urandom)});
      else if (r == 1) wr(A_CTL, 16'($urandom));
      else if (r == 2) wr(A_DATA, 16'($urandom));
      else if (r == 3) wr(A_DATB, 16'($urandom));
      else if (r == 4) wr(8'(8'hA4 + $urandom % 4), 16'($urandom));
      else if (r < 8) step(1'b0, 8'(8'hA0 + $urandom % 4), 16'($urandom));
      else pix(1);
    end
    pix(20);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/denise_sprite_serializer.md
# denise_sprite_serializer

One hardware-sprite channel of Denise. It latches the sprite's position, control and bitplane words from the chip-register bus, compares the horizontal start against the beam pixel counter, and serializes 16 lores pixels as the 2-bit per-sprite video status. The priority logic consumes that status (2 bits per sprite, 8 sprites) to choose between sprites and playfields. Eight instances, one per sprite number, sit between the register bus decode and the priority/colour mux.

## Interface
- SPRNUM, default 0: sprite number 0..7. Sets the register word addresses: POS = 0x140+8*SPRNUM, CTL = +2, DATA = +4, DATB = +6 (byte addresses; compared against reg_address_in[8:1]).
- clk  input  1  system clock. One clock; reset is asynchronous and active-low.
- reset_n  input  1  asynchronous active-low reset.
- clk7_en  input  1  pixel/register enable. All state changes happen only on clk edges with clk7_en=1.
- reg_address_in  input  8  chip register word address, bits [8:1].
- data_in  input  16  chip register write data, valid with reg_address_in.
- hpos  input  9  current horizontal lores pixel position.
- nsprite  output  2  {DATB bit, DATA bit} of the current sprite pixel; 2'b00 = transparent.
- attach  output  1  SPRxCTL[7]; attach request for odd sprites.
- armed  output  1  sprite comparator enabled (debug/status).

## Operation
- Registers, written when clk7_en=1 and address matches:
  - POS: hstart[8:1] <= data_in[7:0]. Bits [15:8] (vstart) ignored; vertical gating is done by Agnus DMA.
  - CTL: hstart[0] <= data_in[0]; attach <= data_in[7]; armed <= 0.
  - DATA: data_latch <= data_in; armed <= 1.
  - DATB: datb_latch <= data_in; armed unchanged.
- State machine (advances only on clk7_en):
  - IDLE: armed=0; comparator ignored; shifter keeps draining.
  - ARMED: waits for hpos == hstart.
  - SHIFT: on match, data_shift <= data_latch, datb_shift <= datb_latch, cnt <= 15. Each later enable shifts both registers left by one, shifting in 0, and decrements cnt. At cnt=0, returns to ARMED, or to IDLE if armed has been cleared.
- nsprite is {datb_shift[15], data_shift[15]}, registered. It is 2'b00 whenever not in SHIFT.
- Match during SHIFT while armed: reload the shifters from the latches and restart cnt=15. This is the same-line retrigger.
- Writes to DATA/DATB during SHIFT update only the latches. The bits being shifted out are unaffected until the next load.
- CTL write during SHIFT: clears armed. The current 16 pixels complete, then the FSM goes to IDLE.
- Simultaneous match and DATA write on the same enable:
  - If armed was already 1: load uses the old latch contents, and the latch takes the new value.
  - If armed was 0: no load on this enable.
- Simultaneous match and CTL write on the same enable: the comparison uses the old hstart and the old armed.
- hstart may be any value 0..511. If no hpos value ever matches, the sprite simply never displays.

## Timing
- Reset values: nsprite=2'b00, attach=0, armed=0. Latches, hstart and shifters are all 0. FSM is IDLE.
- Register write: visible one clk after the enabled edge.
- Pixel latency: hpos==hstart is sampled on enable N. Bit 15 appears on nsprite after enable N+1 (one pixel of latency, which matches the playfield pipeline). Bit 0 appears after enable N+16. Output returns to 00 after enable N+17 unless retriggered.
- clk7_en=0: all state holds and nsprite holds.
- Reset mid-SHIFT: nsprite is 00 immediately (asynchronous). The sprite needs CTL/DATA rewrites to re-arm.

## Structure
- The shared Denise package holds:
  - the register base constants SPR0POS=0x140 and SPR_STRIDE=8;
  - the FSM state encoding (IDLE, ARMED, SHIFT);
  - the nsprite transparent constant 2'b00.
- Natural sub-module: denise_sprite_shifter, the 16-bit dual shift register with load and 4-bit counter. The parent keeps address decode, latches, comparator and FSM.

## Test plan
- Reset release, no writes, sweep hpos 0..511 -> nsprite stays 00, armed=0.
- SPRNUM=0: write POS=0x0040, CTL=0x0000, DATB=0x0000, DATA=0x8001 -> armed=1. At hpos=0x080: nsprite=01 after the next enable, then 14 pixels of 00, then 01, then 00.
- DATA=0xFFFF, DATB=0xAAAA, hstart=0x081 (CTL bit0=1) -> nsprite sequence 11,01,11,01,... for 16 pixels starting one enable after hpos=0x081.
- Write CTL mid-shift at pixel 5 -> the remaining 11 pixels output unchanged. Next line at hstart: no output, armed=0.
- Rewrite DATA=0x0000 during shift, then second match on the same line -> the first burst is unchanged, and the retrigger reloads and outputs 00 pixels.
- Assert reset_n=0 at pixel 8 of a burst -> nsprite=00 with no clock edge needed. attach=0 and armed=0 after release.
